// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - RV32I instruction decoder with a small in-order output buffer
//
// Purpose: decodes each accepted instruction at push time and parks the decoded
// fields together with its PC in a DEPTH-entry FIFO; the head entry drives the
// decoded outputs directly from registers.
//
// Optional feature: define DECODE_ILLEGAL_CNT_EN to add the illegal_cnt output,
// a saturating count of illegal instructions pushed (cleared by reset only).
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   flush               synchronous discard of every buffered entry
//   in_valid/in_ready   push handshake; in_instr, in_pc carried with the push
//   out_valid/out_ready pop handshake; out_pc plus decoded fields of head entry
//   rd, rs1, rs2, imm, aluOp, brFunct3, regWrite, memWrite, memToReg,
//   aluIn1Src, aluIn2Src, branch, jump, jumpReg, illegal   decoded fields
//   illegal_cnt         (DECODE_ILLEGAL_CNT_EN only) illegal push counter
module decode_stage #(
  parameter int PC_W  = 32,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [PC_W-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic [4:0]      rd,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [31:0]     imm,
  output logic [3:0]      aluOp,
  output logic [2:0]      brFunct3,
  output logic            regWrite,
  output logic            memWrite,
  output logic            memToReg,
  output logic            aluIn1Src,
  output logic            aluIn2Src,
  output logic            branch,
  output logic            jump,
  output logic            jumpReg,
  output logic            illegal
`ifdef DECODE_ILLEGAL_CNT_EN
  ,
  output logic [15:0]     illegal_cnt
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_SLL  = 4'b0010;
  localparam logic [3:0] ALU_SLT  = 4'b0011;
  localparam logic [3:0] ALU_SLTU = 4'b0100;
  localparam logic [3:0] ALU_XOR  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_OR   = 4'b1000;
  localparam logic [3:0] ALU_AND  = 4'b1001;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [3:0]  alu_op;
    logic [2:0]  br_funct3;
    logic        reg_write;
    logic        mem_write;
    logic        mem_to_reg;
    logic        alu_in1_src;
    logic        alu_in2_src;
    logic        branch;
    logic        jump;
    logic        jump_reg;
    logic        illegal;
  } dec_t;

  dec_t            dec_d;
  dec_t            dec_mem_q [DEPTH];
  logic [PC_W-1:0] pc_mem_q  [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             in_ready_q, in_ready_d;
  logic             push, pop;

  // Base ALU operation selected by funct3 for OP / OP-IMM (funct7 variants
  // sub/sra are layered on top by the caller).
  function automatic logic [3:0] alu_from_f3(input logic [2:0] f3);
    logic [3:0] op;
    op = ALU_ADD;
    case (f3)
      3'b000:  op = ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  // Instruction decode, evaluated on the incoming instruction.
  always_comb begin
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        legal;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    opc = in_instr[6:0];
    f3  = in_instr[14:12];
    f7  = in_instr[31:25];

    imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
    imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    imm_b = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
    imm_u = {in_instr[31:12], 12'd0};
    imm_j = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};

    legal             = 1'b0;
    dec_d             = '0;
    dec_d.rd          = in_instr[11:7];
    dec_d.rs1         = in_instr[19:15];
    dec_d.rs2         = in_instr[24:20];
    dec_d.alu_in1_src = 1'b1;

    case (opc)
      OPC_LOAD: begin
        legal            = (f3 != 3'b011) && (f3 != 3'b110) && (f3 != 3'b111);
        dec_d.reg_write  = 1'b1;
        dec_d.mem_to_reg = 1'b1;
        dec_d.imm        = imm_i;
      end
      OPC_STORE: begin
        legal           = (f3 <= 3'b010);
        dec_d.mem_write = 1'b1;
        dec_d.imm       = imm_s;
      end
      OPC_OPIMM: begin
        dec_d.reg_write = 1'b1;
        dec_d.imm       = imm_i;
        dec_d.alu_op    = alu_from_f3(f3);
        // Shift-immediates reuse funct7 to pick the shift kind.
        if (f3 == 3'b001) begin
          legal = (f7 == F7_ZERO);
        end else if (f3 == 3'b101) begin
          legal = (f7 == F7_ZERO) || (f7 == F7_ALT);
          if (f7 == F7_ALT) dec_d.alu_op = ALU_SRA;
        end else begin
          legal = 1'b1;
        end
      end
      OPC_OP: begin
        dec_d.reg_write   = 1'b1;
        dec_d.alu_in2_src = 1'b1;
        if (f7 == F7_ZERO) begin
          legal        = 1'b1;
          dec_d.alu_op = alu_from_f3(f3);
        end else if (f7 == F7_ALT && f3 == 3'b000) begin
          legal        = 1'b1;
          dec_d.alu_op = ALU_SUB;
        end else if (f7 == F7_ALT && f3 == 3'b101) begin
          legal        = 1'b1;
          dec_d.alu_op = ALU_SRA;
        end
      end
      OPC_LUI: begin
        legal             = 1'b1;
        dec_d.reg_write   = 1'b1;
        dec_d.alu_in1_src = 1'b0;
        dec_d.imm         = imm_u;
      end
      OPC_AUIPC: begin
        legal           = 1'b1;
        dec_d.reg_write = 1'b1;
        dec_d.imm       = imm_u;
      end
      OPC_JAL: begin
        legal           = 1'b1;
        dec_d.reg_write = 1'b1;
        dec_d.jump      = 1'b1;
        dec_d.imm       = imm_j;
      end
      OPC_JALR: begin
        legal           = (f3 == 3'b000);
        dec_d.reg_write = 1'b1;
        dec_d.jump      = 1'b1;
        dec_d.jump_reg  = 1'b1;
        dec_d.imm       = imm_i;
      end
      OPC_BRANCH: begin
        legal             = (f3 != 3'b010) && (f3 != 3'b011);
        dec_d.branch      = 1'b1;
        dec_d.alu_in2_src = 1'b1;
        dec_d.alu_op      = ALU_SUB;
        dec_d.br_funct3   = f3;
        dec_d.imm         = imm_b;
      end
      default: legal = 1'b0;
    endcase

    // Every listed opcode already ends in 2'b11; kept explicit for clarity.
    if (in_instr[1:0] != 2'b11) legal = 1'b0;

    if (!legal) begin
      dec_d.illegal   = 1'b1;
      dec_d.reg_write = 1'b0;
      dec_d.mem_write = 1'b0;
      dec_d.branch    = 1'b0;
      dec_d.jump      = 1'b0;
      dec_d.alu_op    = ALU_ADD;
    end
  end

  // Buffer control. in_ready is a register, so a pop cannot free a slot for
  // a push in the same cycle when the buffer is full.
  always_comb begin
    push     = in_valid & in_ready_q & ~flush;
    pop      = out_valid & out_ready & ~flush;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
    in_ready_d = (count_d < CNT_W'(DEPTH));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      in_ready_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        dec_mem_q[i] <= '0;
        pc_mem_q[i]  <= '0;
      end
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      in_ready_q <= in_ready_d;
      if (push) begin
        dec_mem_q[wr_ptr_q] <= dec_d;
        pc_mem_q[wr_ptr_q]  <= in_pc;
      end
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (count_q != '0);
  assign out_pc    = pc_mem_q[rd_ptr_q];
  assign rd        = dec_mem_q[rd_ptr_q].rd;
  assign rs1       = dec_mem_q[rd_ptr_q].rs1;
  assign rs2       = dec_mem_q[rd_ptr_q].rs2;
  assign imm       = dec_mem_q[rd_ptr_q].imm;
  assign aluOp     = dec_mem_q[rd_ptr_q].alu_op;
  assign brFunct3  = dec_mem_q[rd_ptr_q].br_funct3;
  assign regWrite  = dec_mem_q[rd_ptr_q].reg_write;
  assign memWrite  = dec_mem_q[rd_ptr_q].mem_write;
  assign memToReg  = dec_mem_q[rd_ptr_q].mem_to_reg;
  assign aluIn1Src = dec_mem_q[rd_ptr_q].alu_in1_src;
  assign aluIn2Src = dec_mem_q[rd_ptr_q].alu_in2_src;
  assign branch    = dec_mem_q[rd_ptr_q].branch;
  assign jump      = dec_mem_q[rd_ptr_q].jump;
  assign jumpReg   = dec_mem_q[rd_ptr_q].jump_reg;
  assign illegal   = dec_mem_q[rd_ptr_q].illegal;

`ifdef DECODE_ILLEGAL_CNT_EN
  logic [15:0] illegal_cnt_q;

  // Counts accepted illegal pushes only; flush leaves it untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_cnt_q <= '0;
    end else if (push && dec_d.illegal && illegal_cnt_q != 16'hFFFF) begin
      illegal_cnt_q <= illegal_cnt_q + 16'd1;
    end
  end

  assign illegal_cnt = illegal_cnt_q;
`endif

endmodule
